// File: rtl/rng_arbiter.sv
// ============================================================================
// Module   : rng_arbiter
// Purpose  : Round-robin sharing of one random source among several requesters,
//            with optional rejection sampling against a programmable bound.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [WIDTH-1:0]           rng_in,
  input  logic [WIDTH-1:0]           bound,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           data_out,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_TRY_W = $clog2(MAX_TRIES) + 1;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SAMPLE = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_ID_W-1:0]  r_rr_ptr;
  logic [c_ID_W-1:0]  r_grant_id;
  logic [c_TRY_W-1:0] r_try_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_err;
  logic               r_busy;

  logic [c_ID_W-1:0]  w_rr_nxt;
  logic [c_ID_W-1:0]  w_gid_nxt;
  logic [c_TRY_W-1:0] w_try_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               w_err_nxt;
  logic               w_busy_nxt;

  logic               w_found;
  logic [c_ID_W-1:0]  w_pick;
  logic               w_accept;
  logic               w_last;
  logic               w_req_held;
  logic [c_ID_W-1:0]  w_gid_inc;

  // Modulo-NUM_REQ index; arguments never exceed 2*NUM_REQ-1.
  function automatic logic [c_ID_W-1:0] f_wrap(input int v);
    return (v >= NUM_REQ) ? c_ID_W'(v - NUM_REQ) : c_ID_W'(v);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_found = 1'b1;
        w_pick  = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  assign w_accept   = (bound == '0) || (rng_in < bound);
  assign w_last     = (r_try_cnt == c_TRY_W'(MAX_TRIES - 1));
  assign w_req_held = req[r_grant_id];
  assign w_gid_inc  = f_wrap(int'(r_grant_id) + 1);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_found) w_state_nxt = c_ST_SAMPLE;
      c_ST_SAMPLE: begin
        if (!w_req_held)             w_state_nxt = c_ST_IDLE;
        else if (w_accept || w_last) w_state_nxt = c_ST_DONE;
      end
      c_ST_DONE:   w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping counters.
  always_comb begin
    w_ack_nxt  = '0;
    w_data_nxt = r_data_out;
    w_err_nxt  = r_err;
    w_gid_nxt  = r_grant_id;
    w_rr_nxt   = r_rr_ptr;
    w_try_nxt  = r_try_cnt;
    w_busy_nxt = (w_state_nxt != c_ST_IDLE);
    case (r_state)
      c_ST_IDLE: begin
        if (w_found) begin
          w_gid_nxt = w_pick;
          w_try_nxt = '0;
        end
      end
      c_ST_SAMPLE: begin
        if (!w_req_held) begin
          w_rr_nxt = w_gid_inc;
        end else if (w_accept) begin
          w_data_nxt            = rng_in;
          w_err_nxt             = 1'b0;
          w_ack_nxt[r_grant_id] = 1'b1;
        end else if (w_last) begin
          w_data_nxt            = '0;
          w_err_nxt             = 1'b1;
          w_ack_nxt[r_grant_id] = 1'b1;
        end else begin
          w_try_nxt = r_try_cnt + c_TRY_W'(1);
        end
      end
      c_ST_DONE: w_rr_nxt = w_gid_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_try_cnt  <= '0;
      r_ack      <= '0;
      r_data_out <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_nxt;
      r_grant_id <= w_gid_nxt;
      r_try_cnt  <= w_try_nxt;
      r_ack      <= w_ack_nxt;
      r_data_out <= w_data_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign ack      = r_ack;
  assign data_out = r_data_out;
  assign err      = r_err;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_rng_arbiter.sv
// ============================================================================
// Module   : tb_rng_arbiter
// Purpose  : Directed vector table plus hand sequences for rng_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_TRIES = 16;

  logic               clock = 1'b0;
  logic               nreset;
  logic [WIDTH-1:0]   rng_in;
  logic [WIDTH-1:0]   bound;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [WIDTH-1:0]   data_out;
  logic               err;
  logic               busy;
  logic [1:0]         grant_id;

  rng_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clock   (clock),
    .nreset  (nreset),
    .rng_in  (rng_in),
    .bound   (bound),
    .req     (req),
    .ack     (ack),
    .data_out(data_out),
    .err     (err),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       nrst;
    logic [3:0] req;
    logic [7:0] bound;
    logic [7:0] rng;
    logic [3:0] e_ack;
    logic [7:0] e_data;
    logic       e_err;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_ack, input logic [7:0] e_data,
                         input logic e_err, input logic e_busy, input logic [1:0] e_gid);
    chk({tag, ".ack"},      32'(ack),      32'(e_ack));
    chk({tag, ".data"},     32'(data_out), 32'(e_data));
    chk({tag, ".err"},      32'(err),      32'(e_err));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(e_gid));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int         k;
    int         last_cyc;
    logic [3:0] reassert;

    //            nrst  req      bound  rng    | ack      data   err  busy gid
    vt[0]  = '{1'b0, 4'b0000, 8'd0,  8'd0,   4'b0000, 8'h00, 1'b0, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 4'b0010, 8'd0,  8'h5A,  4'b0000, 8'h00, 1'b0, 1'b1, 2'd1};
    vt[2]  = '{1'b1, 4'b0010, 8'd0,  8'h5A,  4'b0010, 8'h5A, 1'b0, 1'b1, 2'd1};
    vt[3]  = '{1'b1, 4'b0000, 8'd0,  8'h5A,  4'b0000, 8'h5A, 1'b0, 1'b0, 2'd1};
    vt[4]  = '{1'b1, 4'b0001, 8'd10, 8'd200, 4'b0000, 8'h5A, 1'b0, 1'b1, 2'd0};
    vt[5]  = '{1'b1, 4'b0001, 8'd10, 8'd200, 4'b0000, 8'h5A, 1'b0, 1'b1, 2'd0};
    vt[6]  = '{1'b1, 4'b0001, 8'd10, 8'd150, 4'b0000, 8'h5A, 1'b0, 1'b1, 2'd0};
    vt[7]  = '{1'b1, 4'b0001, 8'd10, 8'd7,   4'b0001, 8'd7,  1'b0, 1'b1, 2'd0};
    vt[8]  = '{1'b1, 4'b0000, 8'd10, 8'd7,   4'b0000, 8'd7,  1'b0, 1'b0, 2'd0};
    vt[9]  = '{1'b1, 4'b1000, 8'd10, 8'd0,   4'b0000, 8'd7,  1'b0, 1'b1, 2'd3};
    vt[10] = '{1'b1, 4'b1000, 8'd10, 8'd10,  4'b0000, 8'd7,  1'b0, 1'b1, 2'd3};
    vt[11] = '{1'b1, 4'b1000, 8'd10, 8'd9,   4'b1000, 8'd9,  1'b0, 1'b1, 2'd3};
    vt[12] = '{1'b1, 4'b0000, 8'd10, 8'd9,   4'b0000, 8'd9,  1'b0, 1'b0, 2'd3};

    nreset = 1'b0;
    req    = '0;
    bound  = '0;
    rng_in = '0;

    for (int i = 0; i < 13; i++) begin
      nreset = vt[i].nrst;
      req    = vt[i].req;
      bound  = vt[i].bound;
      rng_in = vt[i].rng;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_data, vt[i].e_err,
              vt[i].e_busy, vt[i].e_gid);
    end

    // Round-robin: everyone requests, drops after ack, reasserts a cycle later.
    bound    = 8'd0;
    rng_in   = 8'h33;
    req      = 4'b1111;
    reassert = '0;
    k        = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && k < 5; cyc++) begin
      step();
      req      = req | reassert;
      reassert = '0;
      if (ack != '0) begin
        chk($sformatf("rr_ack%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
        chk($sformatf("rr_data%0d", k), 32'(data_out), 32'h33);
        if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        req      = req & ~ack;
        reassert = ack;
        k++;
      end
    end
    chk("rr_count", 32'(k), 32'd5);
    req = '0;
    step();
    step();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Exhaustion: bound 1 with rng 0xFF never accepts.
    req    = 4'b0100;
    bound  = 8'd1;
    rng_in = 8'hFF;
    step();
    chk_all("exh_grant", 4'b0000, 8'h33, 1'b0, 1'b1, 2'd2);
    for (int i = 1; i < MAX_TRIES; i++) begin
      step();
      chk($sformatf("exh_noack%0d", i), 32'(ack), 32'd0);
      chk($sformatf("exh_busy%0d", i), 32'(busy), 32'd1);
    end
    step();
    chk_all("exh_done", 4'b0100, 8'h00, 1'b1, 1'b1, 2'd2);
    req = '0;
    step();
    chk_all("exh_idle", 4'b0000, 8'h00, 1'b1, 1'b0, 2'd2);

    // Abort: requester 2 withdraws mid-SAMPLE, requester 3 is served next.
    req = 4'b0100;
    step();
    chk_all("abt_grant", 4'b0000, 8'h00, 1'b1, 1'b1, 2'd2);
    req = 4'b1100;
    step();
    chk_all("abt_retry", 4'b0000, 8'h00, 1'b1, 1'b1, 2'd2);
    req = 4'b1000;
    step();
    chk_all("abt_abort", 4'b0000, 8'h00, 1'b1, 1'b0, 2'd2);
    bound  = 8'd0;
    rng_in = 8'h66;
    step();
    chk_all("abt_grant3", 4'b0000, 8'h00, 1'b1, 1'b1, 2'd3);
    step();
    chk_all("abt_ack3", 4'b1000, 8'h66, 1'b0, 1'b1, 2'd3);
    req = '0;
    step();
    chk("abt_idle_busy", 32'(busy), 32'd0);

    // Reset mid-SAMPLE, after a delivery has advanced the pointer past 1.
    req    = 4'b0010;
    rng_in = 8'h11;
    step();
    step();
    chk_all("rst_pre_ack", 4'b0010, 8'h11, 1'b0, 1'b1, 2'd1);
    req = '0;
    step();
    req    = 4'b0100;
    bound  = 8'd1;
    rng_in = 8'hFF;
    step();
    step();
    step();
    chk_all("rst_loop", 4'b0000, 8'h11, 1'b0, 1'b1, 2'd2);
    nreset = 1'b0;
    step();
    chk_all("rst_zero", 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
    nreset = 1'b1;
    req    = 4'b1111;
    bound  = 8'd0;
    rng_in = 8'h42;
    step();
    chk_all("rst_grant0", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);
    step();
    chk_all("rst_ack0", 4'b0001, 8'h42, 1'b0, 1'b1, 2'd0);
    req = '0;
    step();
    chk("rst_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
